// File: rtl/wb_machine_timer.sv
// RISC-V machine timer as a Wishbone classic slave: prescaled 64-bit mtime,
// 64-bit mtimecmp, CTRL/STATUS registers and a level machine-timer interrupt.
module wb_machine_timer #(
  parameter logic [15:0] RESET_DIV = 16'd0,
  parameter logic        RESET_EN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o,
  output logic [63:0] mtime_o
);

  localparam logic [2:0] ADR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADR_CTRL     = 3'd4;
  localparam logic [2:0] ADR_STATUS   = 3'd5;

  // Byte-lane merge: lanes with sel=1 take the new data, the rest keep the old value.
  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_en;
  logic        r_irq_en;
  logic [15:0] r_div;
  logic [15:0] r_cnt;
  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_irq;

  logic        w_req;
  logic        w_wr;
  logic [2:0]  w_idx;
  logic        w_tick;
  logic        w_pend;
  logic [31:0] w_ctrl;
  logic [31:0] w_ctrl_new;
  logic [31:0] w_rdata;
  logic        w_lanes;
  logic        w_mtime_wr;
  logic        w_ctrl_wr;
  logic        w_unused;

  assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr       = w_req & wb_we_i;
  assign w_idx      = wb_adr_i[4:2];
  assign w_lanes    = |wb_sel_i;
  assign w_pend     = (r_mtime >= r_mtimecmp);
  assign w_tick     = r_en & (r_cnt == r_div);
  assign w_ctrl     = {r_div, 14'd0, r_irq_en, r_en};
  assign w_ctrl_new = f_merge(w_ctrl, wb_dat_i, wb_sel_i);
  assign w_ctrl_wr  = w_wr & w_lanes & (w_idx == ADR_CTRL);
  assign w_mtime_wr = w_wr & w_lanes & ((w_idx == ADR_MTIME_LO) | (w_idx == ADR_MTIME_HI));
  assign w_unused   = &{1'b0, wb_adr_i[31:5], wb_adr_i[1:0], w_ctrl_new[15:2]};

  // Read mux over the pre-edge register values.
  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      ADR_MTIME_LO: w_rdata = r_mtime[31:0];
      ADR_MTIME_HI: w_rdata = r_mtime[63:32];
      ADR_CMP_LO:   w_rdata = r_mtimecmp[31:0];
      ADR_CMP_HI:   w_rdata = r_mtimecmp[63:32];
      ADR_CTRL:     w_rdata = w_ctrl;
      ADR_STATUS:   w_rdata = {31'd0, w_pend};
      default:      w_rdata = 32'd0;
    endcase
  end

  // Bus response: one-cycle ack, read data captured at the request edge and held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_req;
      if (w_req && !wb_we_i) begin
        r_dat <= w_rdata;
      end else begin
        r_dat <= r_dat;
      end
    end
  end

  // Control register and prescaler; any CTRL write restarts the divider phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en     <= RESET_EN;
      r_irq_en <= 1'b0;
      r_div    <= RESET_DIV;
      r_cnt    <= 16'd0;
    end else begin
      if (w_ctrl_wr) begin
        r_en     <= w_ctrl_new[0];
        r_irq_en <= w_ctrl_new[1];
        r_div    <= w_ctrl_new[31:16];
        r_cnt    <= 16'd0;
      end else if (w_tick) begin
        r_cnt <= 16'd0;
      end else if (r_en) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // mtime: a bus write to either half takes priority over the tick increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= 64'd0;
    end else if (w_mtime_wr) begin
      if (w_idx == ADR_MTIME_LO) begin
        r_mtime[31:0] <= f_merge(r_mtime[31:0], wb_dat_i, wb_sel_i);
      end else begin
        r_mtime[63:32] <= f_merge(r_mtime[63:32], wb_dat_i, wb_sel_i);
      end
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end else begin
      r_mtime <= r_mtime;
    end
  end

  // mtimecmp halves, byte-lane writable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (w_wr && (w_idx == ADR_CMP_LO)) begin
      r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], wb_dat_i, wb_sel_i);
    end else if (w_wr && (w_idx == ADR_CMP_HI)) begin
      r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], wb_dat_i, wb_sel_i);
    end else begin
      r_mtimecmp <= r_mtimecmp;
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & w_pend;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;
  assign mtime_o  = r_mtime;

endmodule

// File: tb/tb_wb_machine_timer.sv
// Directed bench for wb_machine_timer: register access, prescaling, wrap,
// interrupt timing, byte lanes, ack pattern and reset mid-transfer.
module tb_wb_machine_timer;

  localparam logic [31:0] A_MTLO  = 32'h00;
  localparam logic [31:0] A_MTHI  = 32'h04;
  localparam logic [31:0] A_CMPLO = 32'h08;
  localparam logic [31:0] A_CMPHI = 32'h0C;
  localparam logic [31:0] A_CTRL  = 32'h10;
  localparam logic [31:0] A_STAT  = 32'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr_i = 32'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [3:0]  wb_sel_i = 4'd0;
  logic        wb_we_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        irq_o;
  logic [63:0] mtime_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] d;

  wb_machine_timer dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq_o    (irq_o),
    .mtime_o  (mtime_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transfer: request at the first rising edge after the strobe, ack expected right after it.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat);
    @(negedge clk);
    if (wb_ack_o) @(negedge clk);
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_latency", {63'd0, wb_ack_o}, 64'd1);
    rdat     = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] unused_rd;
    xfer(1'b1, adr, dat, sel, unused_rd);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] rdat);
    xfer(1'b0, adr, 32'd0, 4'hF, rdat);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ack", {63'd0, wb_ack_o}, 64'd0);
    chk("rst_dat", {32'd0, wb_dat_o}, 64'd0);
    chk("rst_irq", {63'd0, irq_o}, 64'd0);
    chk("rst_mtime", mtime_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(A_MTLO, d);  chk("rst_mtlo", {32'd0, d}, 64'h0);
    rd(A_CMPLO, d); chk("rst_cmplo", {32'd0, d}, 64'hFFFF_FFFF);
    rd(A_CMPHI, d); chk("rst_cmphi", {32'd0, d}, 64'hFFFF_FFFF);
    rd(A_CTRL, d);  chk("rst_ctrl", {32'd0, d}, 64'h0);
    rd(32'h18, d);  chk("hole_18", {32'd0, d}, 64'h0);
    wr(32'h1C, 32'hDEAD_BEEF, 4'hF);
    rd(32'h1C, d);  chk("hole_1c", {32'd0, d}, 64'h0);

    // Byte lanes
    wr(A_CMPLO, 32'h1122_3344, 4'b0101);
    rd(A_CMPLO, d); chk("sel_0101", {32'd0, d}, 64'hFF22_FF44);
    wr(A_CMPLO, 32'h0000_0000, 4'b0000);
    rd(A_CMPLO, d); chk("sel_0000", {32'd0, d}, 64'hFF22_FF44);

    // DIV=0 counting: enable at edge E0, reads at E11 and E13
    wr(A_CTRL, 32'h0000_0001, 4'hF);
    repeat (10) @(posedge clk);
    rd(A_MTLO, d); chk("cnt_div0_a", {32'd0, d}, 64'd10);
    rd(A_MTLO, d); chk("cnt_div0_b", {32'd0, d}, 64'd12);

    // DIV=3: one tick every 4 cycles, reads every 2 cycles
    wr(A_CTRL, 32'h0000_0000, 4'hF);
    wr(A_MTLO, 32'h0, 4'hF);
    wr(A_MTHI, 32'h0, 4'hF);
    wr(A_CTRL, 32'h0003_0001, 4'hF);
    for (int i = 0; i < 6; i++) begin
      rd(A_MTLO, d);
      chk("cnt_div3", {32'd0, d}, 64'((1 + 2 * i) / 4));
    end

    // Carry from low to high word
    wr(A_CTRL, 32'h0000_0000, 4'hF);
    wr(A_MTLO, 32'hFFFF_FFFE, 4'hF);
    wr(A_MTHI, 32'h0, 4'hF);
    wr(A_CTRL, 32'h0000_0001, 4'hF);
    chk("carry_t0", mtime_o, 64'h0000_0000_FFFF_FFFE);
    @(posedge clk); #1;
    chk("carry_t1", mtime_o, 64'h0000_0000_FFFF_FFFF);
    wr(A_CTRL, 32'h0000_0000, 4'hF);
    rd(A_MTHI, d); chk("carry_hi", {32'd0, d}, 64'd1);
    rd(A_MTLO, d); chk("carry_lo", {32'd0, d}, 64'd0);

    // Full wrap
    wr(A_MTLO, 32'hFFFF_FFFF, 4'hF);
    wr(A_MTHI, 32'hFFFF_FFFF, 4'hF);
    wr(A_CTRL, 32'h0000_0001, 4'hF);
    chk("wrap_t0", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    chk("wrap_t1", mtime_o, 64'd0);
    chk("wrap_irq", {63'd0, irq_o}, 64'd0);
    wr(A_CTRL, 32'h0000_0000, 4'hF);

    // Interrupt: mtimecmp=0x20, enable at J0, irq after J33
    wr(A_CMPLO, 32'h20, 4'hF);
    wr(A_CMPHI, 32'h0, 4'hF);
    wr(A_MTLO, 32'h0, 4'hF);
    wr(A_MTHI, 32'h0, 4'hF);
    wr(A_CTRL, 32'h0000_0003, 4'hF);
    repeat (32) @(posedge clk);
    #1;
    chk("irq_mt20", mtime_o, 64'h20);
    chk("irq_before", {63'd0, irq_o}, 64'd0);
    @(posedge clk); #1;
    chk("irq_rise", {63'd0, irq_o}, 64'd1);
    rd(A_STAT, d); chk("status_pend", {32'd0, d}, 64'd1);
    @(posedge clk); #1;
    chk("dat_hold", {32'd0, wb_dat_o}, 64'd1);
    wr(A_CMPHI, 32'h1, 4'hF);
    chk("irq_hold", {63'd0, irq_o}, 64'd1);
    @(posedge clk); #1;
    chk("irq_fall", {63'd0, irq_o}, 64'd0);
    rd(A_STAT, d); chk("status_clr", {32'd0, d}, 64'd0);

    // Held strobe: three reads of STATUS back to back
    @(negedge clk);
    if (wb_ack_o) @(negedge clk);
    wb_adr_i = A_STAT;
    wb_we_i  = 1'b0;
    wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    chk("held_ack0", {63'd0, wb_ack_o}, 64'd0);
    for (int i = 1; i < 6; i++) begin
      @(posedge clk); #1;
      chk("held_ack", {63'd0, wb_ack_o}, 64'(i % 2));
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;

    // Reset right after a write request
    @(negedge clk);
    if (wb_ack_o) @(negedge clk);
    wb_adr_i = A_MTHI;
    wb_dat_i = 32'h0000_ABCD;
    wb_we_i  = 1'b1;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ack", {63'd0, wb_ack_o}, 64'd0);
    chk("rst_mid_mtime", mtime_o, 64'd0);
    chk("rst_mid_irq", {63'd0, irq_o}, 64'd0);
    chk("rst_mid_dat", {32'd0, wb_dat_o}, 64'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd(A_CMPLO, d); chk("rst_mid_cmplo", {32'd0, d}, 64'hFFFF_FFFF);
    rd(A_CMPHI, d); chk("rst_mid_cmphi", {32'd0, d}, 64'hFFFF_FFFF);
    rd(A_CTRL, d);  chk("rst_mid_ctrl", {32'd0, d}, 64'h0);
    rd(A_MTHI, d);  chk("rst_mid_mthi", {32'd0, d}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_machine_timer.md
Name: wb_machine_timer

Overview:
- Wishbone classic-cycle slave (responder) on the SoC data bus, sitting behind the interconnect next to the other memory-mapped peripherals.
- Implements the RISC-V machine timer: 64-bit mtime counter with programmable prescaler, 64-bit mtimecmp compare register, control/status registers and a level machine-timer interrupt to the core.
- Answers every access it is selected for with a registered single-cycle ack, honouring wb_sel_i byte lanes on writes.

Parameters:
- RESET_DIV, 16'd0, reset value of CTRL.DIV; prescaler divides clk by DIV+1.
- RESET_EN, 1'b0, reset value of CTRL.EN.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb_adr_i  input  32  byte address; only bits [4:2] decoded, interconnect does base select.
- wb_dat_i  input  32  write data.
- wb_sel_i  input  4  byte enables, bit n = byte lane n.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_cyc_i  input  1  bus cycle valid.
- wb_stb_i  input  1  strobe.
- wb_dat_o  output  32  read data, valid in ack cycle.
- wb_ack_o  output  1  transfer acknowledge.
- irq_o  output  1  machine timer interrupt, level.
- mtime_o  output  64  current mtime, for CSR time/timeh shadow.

Behaviour:
- Register map (offset = adr[4:2]*4):
  - 0x00 MTIME_LO, RW.
  - 0x04 MTIME_HI, RW.
  - 0x08 MTIMECMP_LO, RW.
  - 0x0C MTIMECMP_HI, RW.
  - 0x10 CTRL, RW: [0] EN, [1] IRQ_EN, [31:16] DIV, other bits read 0.
  - 0x14 STATUS, RO: [0] PEND = (mtime >= mtimecmp), unsigned 64-bit.
  - 0x18/0x1C: read 0, writes ignored, still acked.
- Reset values:
  - mtime = 0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - CTRL = {RESET_DIV, 14'b0, 1'b0, RESET_EN}.
  - Prescaler count = 0.
  - wb_ack_o = 0, wb_dat_o = 0, irq_o = 0.
- Handshake:
  - Request = wb_cyc_i & wb_stb_i & ~wb_ack_o, sampled at rising edge.
  - wb_ack_o goes high the following cycle for exactly one cycle; latency 1.
  - ack is never high two consecutive cycles, so a master holding stb gets one ack every 2 cycles.
  - Each ack completes exactly one transfer.
  - If cyc/stb drop while ack is pending, ack is still issued; the write has already been committed at the request edge.
- Write:
  - Committed at the request edge; only lanes with wb_sel_i=1 update, others hold.
  - wb_sel_i=0 is a legal no-op and is still acked.
  - STATUS writes are ignored.
- Read:
  - wb_dat_o is loaded at the request edge with the register value as it stood before that edge; full word regardless of wb_sel_i.
  - wb_dat_o holds its value outside ack cycles.
- Prescaler:
  - When EN=1: if cnt == DIV then tick, cnt <= 0; else cnt <= cnt+1.
  - When EN=0: cnt holds, no tick.
  - DIV=0 gives a tick every cycle.
  - A write to CTRL clears cnt.
- mtime:
  - On tick, mtime <= mtime + 1, wrapping from all-ones to 0.
  - In a cycle where any byte of MTIME_LO/HI is written, the write wins: no increment that cycle; unwritten bytes hold.
- mtime_o = mtime register, combinational from the flop.
- irq_o:
  - Registered: irq_o <= IRQ_EN & PEND, one cycle after the condition.
  - Deasserts one cycle after mtimecmp is raised above mtime or IRQ_EN is cleared.
- Reset mid-transfer: all state returns to reset values immediately; a pending ack is dropped and the master must retry.

Test Plan:
- Reset, EN=0: read 0x00 -> ack exactly 1 cycle after stb, wb_dat_o=0; read 0x08 -> 0xFFFFFFFF; read 0x10 -> 0; irq_o=0.
- Write CTRL=0x0000_0001 (DIV=0, EN=1), wait 10 cycles, read MTIME_LO -> value increments by 1 per cycle; consistent with enable edge ±1. Then write CTRL=0x0003_0001 -> MTIME_LO advances by 1 every 4 cycles.
- Write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0 with DIV=0, EN=1 -> after 2 ticks MTIME_HI=1, MTIME_LO=0. Separately, write mtime=all-ones -> wraps to 0, no spurious irq.
- Set mtimecmp=0x0000_0000_0000_0020, IRQ_EN=1, EN=1, mtime=0:
  - irq_o rises exactly 1 cycle after mtime reaches 0x20; STATUS reads 1.
  - Writing MTIMECMP_HI=1 drops irq_o the next cycle.
- Byte lanes: write 0x11223344 to MTIMECMP_LO with sel=4'b0101 from reset -> readback 0xFF22FF44; sel=0 write -> unchanged, still acked.
- Held stb for 3 back-to-back reads of 0x14 -> ack pattern 0,1,0,1,0,1. Assert rst the cycle after a request -> no ack, all registers at reset values.
